// File: rtl/icache.sv
// Direct-mapped, one-word-per-frame instruction cache with combinational lookup.
// Misses are filled from the memory controller through the iREN/iwait/iload port.
module icache #(
    parameter int SETS  = 16,
    parameter int IDX_W = 4,
    parameter int TAG_W = 26
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    input  logic        halt,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] FILL = 1'b1;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [31:0]      word;
    } frame_t;

    logic [0:0]       state;
    logic [31:0]      fill_addr;
    logic [SETS-1:0]  valid;
    frame_t           frames [SETS];

    logic [IDX_W-1:0] req_idx, fill_idx;
    logic [TAG_W-1:0] req_tag, fill_tag;
    logic             lookup, hit, miss, fill_done;

    assign req_idx  = imemaddr[1+IDX_W:2];
    assign req_tag  = imemaddr[31:2+IDX_W];
    assign fill_idx = fill_addr[1+IDX_W:2];
    assign fill_tag = fill_addr[31:2+IDX_W];

    assign lookup    = (state == IDLE) && imemREN && !halt;
    assign hit       = lookup && valid[req_idx] && (frames[req_idx].tag == req_tag);
    assign miss      = lookup && !hit;
    // A halt in FILL abandons the fill, even if memory grants it that cycle.
    assign fill_done = (state == FILL) && !halt && !iwait;

    assign ihit     = hit;
    assign imemload = hit ? frames[req_idx].word : 32'h0;
    assign iREN     = (state == FILL);
    assign iaddr    = (state == FILL) ? fill_addr : 32'h0;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            fill_addr  <= 32'h0;
            valid      <= '0;
            hit_count  <= 16'h0;
            miss_count <= 16'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (miss) begin
                        fill_addr <= imemaddr & ~32'h3;
                        state     <= FILL;
                    end
                end
                default: begin
                    if (halt) begin
                        state <= IDLE;
                    end else if (!iwait) begin
                        valid[fill_idx] <= 1'b1;
                        state           <= IDLE;
                    end
                end
            endcase
            if (hit && hit_count != 16'hFFFF)
                hit_count <= hit_count + 16'h1;
            if (miss && miss_count != 16'hFFFF)
                miss_count <= miss_count + 16'h1;
        end
    end

    // Tag/data need no reset: valid bits gate every read.
    always_ff @(posedge CLK) begin
        if (fill_done)
            frames[fill_idx] <= '{tag: fill_tag, word: iload};
    end
endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: a per-cycle scoreboard against a cache model
// plus hand-computed literal checks for each scenario.
module tb_icache;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        imemREN = 1'b0;
    logic [31:0] imemaddr = 32'h0;
    logic        halt = 1'b0;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait = 1'b1;
    logic [31:0] iload = 32'h0;
    logic [15:0] hit_count, miss_count;

    int vectors = 0;
    int errors  = 0;

    icache #(.SETS(16), .IDX_W(4), .TAG_W(26)) dut (
        .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr), .halt(halt),
        .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
        .iwait(iwait), .iload(iload), .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            if (errors < 40)
                $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Cache model: which word lives in each frame and whether a fill is pending.
    bit          m_valid [16];
    logic [31:0] m_waddr [16];
    logic [31:0] m_data  [16];
    bit          m_busy;
    logic [31:0] m_faddr;
    int          m_hits, m_misses;

    function automatic bit m_lookup(input logic [31:0] a);
        int idx;
        idx = int'((a >> 2) % 16);
        return m_valid[idx] && (m_waddr[idx] == (a & ~32'h3));
    endfunction

    always @(posedge CLK) begin
        if (RST) begin
            foreach (m_valid[i]) m_valid[i] = 1'b0;
            m_busy = 1'b0; m_faddr = 32'h0; m_hits = 0; m_misses = 0;
        end else if (!m_busy) begin
            if (imemREN && !halt) begin
                if (m_lookup(imemaddr)) begin
                    if (m_hits < 65535) m_hits++;
                end else begin
                    m_busy = 1'b1; m_faddr = imemaddr & ~32'h3;
                    if (m_misses < 65535) m_misses++;
                end
            end
        end else if (halt) begin
            m_busy = 1'b0;
        end else if (!iwait) begin
            m_valid[(m_faddr >> 2) % 16] = 1'b1;
            m_waddr[(m_faddr >> 2) % 16] = m_faddr;
            m_data [(m_faddr >> 2) % 16] = iload;
            m_busy = 1'b0;
        end
    end

    always @(negedge CLK) begin
        if (!RST) begin
            logic        e_hit;
            e_hit = !m_busy && imemREN && !halt && m_lookup(imemaddr);
            chk("ihit", {31'h0, ihit}, {31'h0, e_hit});
            chk("imemload", imemload, e_hit ? m_data[(imemaddr >> 2) % 16] : 32'h0);
            chk("iREN", {31'h0, iREN}, {31'h0, m_busy});
            chk("iaddr", iaddr, m_busy ? m_faddr : 32'h0);
            chk("hit_count", {16'h0, hit_count}, m_hits);
            chk("miss_count", {16'h0, miss_count}, m_misses);
        end
    end

    task automatic tick();
        @(posedge CLK); #1;
    endtask

    initial begin
        tick(); tick();
        #2;
        chk("rst_ihit", {31'h0, ihit}, 32'h0);
        chk("rst_iREN", {31'h0, iREN}, 32'h0);
        chk("rst_iaddr", iaddr, 32'h0);
        chk("rst_imemload", imemload, 32'h0);
        chk("rst_counts", {hit_count, miss_count}, 32'h0);
        RST = 1'b0;

        // Cold miss on 0x0 with three wait cycles.
        tick(); imemREN = 1'b1; imemaddr = 32'h0; iwait = 1'b1; #2;
        chk("cold_ihit", {31'h0, ihit}, 32'h0);
        tick(); #2;
        chk("cold_iREN", {31'h0, iREN}, 32'h1);
        chk("cold_iaddr", iaddr, 32'h0);
        tick(); tick();
        iwait = 1'b0; iload = 32'h2002_0004;
        tick(); iwait = 1'b1; #2;
        chk("fill_hit", {31'h0, ihit}, 32'h1);
        chk("fill_data", imemload, 32'h2002_0004);
        chk("fill_miss_cnt", {16'h0, miss_count}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick(); #2;
            chk("hold_hit", {31'h0, ihit}, 32'h1);
            chk("hold_iREN", {31'h0, iREN}, 32'h0);
        end
        imemaddr = 32'h2; #1;
        chk("lowbits_data", imemload, 32'h2002_0004);

        // Conflict eviction: 0x40 shares frame 0.
        tick(); imemaddr = 32'h40; iwait = 1'b0; iload = 32'hDEAD_BEEF; #2;
        chk("hit_count5", {16'h0, hit_count}, 32'd5);
        chk("conf_ihit", {31'h0, ihit}, 32'h0);
        tick(); #2;
        chk("conf_iaddr", iaddr, 32'h40);
        tick(); #2;
        chk("conf_data", imemload, 32'hDEAD_BEEF);
        chk("conf_miss_cnt", {16'h0, miss_count}, 32'd2);
        tick(); imemaddr = 32'h0; iload = 32'h2002_0004; #2;
        chk("evict_ihit", {31'h0, ihit}, 32'h0);
        tick(); #2;
        chk("evict_miss_cnt", {16'h0, miss_count}, 32'd3);
        tick(); imemREN = 1'b0;

        // Redirect mid-fill.
        tick(); imemREN = 1'b1; imemaddr = 32'h8; iwait = 1'b1;
        tick(); imemaddr = 32'h10;
        tick(); iwait = 1'b0; iload = 32'h1111_1111;
        tick(); iload = 32'h5555_5555; #2;
        chk("redir_ihit", {31'h0, ihit}, 32'h0);
        tick(); #2;
        chk("redir_iaddr", iaddr, 32'h10);
        tick(); imemaddr = 32'h8; #2;
        chk("redir_old_hit", {31'h0, ihit}, 32'h1);
        chk("redir_old_data", imemload, 32'h1111_1111);

        // Halt during fill of 0x20.
        tick(); imemaddr = 32'h20; iwait = 1'b1;
        tick(); halt = 1'b1; iwait = 1'b0; iload = 32'hBAD0_BAD0; #2;
        chk("halt_fill_iREN", {31'h0, iREN}, 32'h1);
        tick(); #2;
        chk("halt_iREN", {31'h0, iREN}, 32'h0);
        chk("halt_ihit", {31'h0, ihit}, 32'h0);
        tick(); #2;
        chk("halt_ihit2", {31'h0, ihit}, 32'h0);
        halt = 1'b0; iwait = 1'b1; #1;
        chk("halt_remiss", {31'h0, ihit}, 32'h0);
        tick(); #2;
        chk("halt_iaddr", iaddr, 32'h20);
        iwait = 1'b0; iload = 32'h2020_2020;
        tick();

        // Async reset mid-fill; 0x0 (cached) must miss afterwards.
        imemaddr = 32'h0; #2;
        chk("pre_rst_hit", {31'h0, ihit}, 32'h1);
        tick(); imemaddr = 32'h30; iwait = 1'b1;
        tick(); #2;
        chk("pre_rst_iREN", {31'h0, iREN}, 32'h1);
        RST = 1'b1; #1;
        chk("async_iREN", {31'h0, iREN}, 32'h0);
        chk("async_counts", {hit_count, miss_count}, 32'h0);
        tick(); RST = 1'b0; imemaddr = 32'h0; #2;
        chk("post_rst_ihit", {31'h0, ihit}, 32'h0);
        tick(); #2;
        chk("post_rst_iaddr", iaddr, 32'h0);
        iwait = 1'b0; iload = 32'h2002_0004;
        tick();

        // Saturation of hit_count.
        for (int i = 0; i < 65540; i++) tick();
        #2;
        chk("sat_hit", {16'h0, hit_count}, 32'h0000_FFFF);
        tick(); tick(); #2;
        chk("sat_hold", {16'h0, hit_count}, 32'h0000_FFFF);
        chk("sat_ihit", {31'h0, ihit}, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
